// File: rtl/axis_s_rx_buffer_pkg.sv
// Shared types and width helpers for the AXI-Stream receive buffer.
package axis_s_pkg;

  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    OVER = 2'd2
  } rx_state_t;

  // Bits needed to hold any value in 0..n
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/axis_s_rx_buffer_if.sv
// AXI-Stream beat bus between a stream master and the receive buffer.
interface axis_s_if
  import axis_s_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_s_rx_buffer_fifo.sv
// Generic first-word-fall-through synchronous FIFO; head word is read straight from storage.
module axis_s_fifo
  import axis_s_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        head,
  output logic                    full,
  output logic                    empty,
  output logic [cnt_w(DEPTH)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;
  assign head  = mem[rd_ptr];

  // Storage carries no reset; only occupancy tracking is cleared
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/axis_s_rx_buffer.sv
// AXI-Stream slave endpoint: buffers beats in a FWFT FIFO, tracks packet framing and length errors.
module axis_s_rx_buffer
  import axis_s_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = 8,
  parameter int MAX_PKT_LEN = 4
) (
  input  logic                  clk,
  input  logic                  areset,
  axis_s_if.slave               s_axis,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_last,
  output logic                  dout_valid,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]            pkt_count,
  output logic                  len_err
);
  localparam int BW = cnt_w(MAX_PKT_LEN + 1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_PKT_LEN);
  localparam logic [BW-1:0] BEAT_SAT = BW'(MAX_PKT_LEN + 1);

  rx_state_t     state;
  logic [BW-1:0] beat_cnt;
  logic          full;
  logic          empty;
  logic          accept;

  // tready comes from registered occupancy only, never from tvalid
  assign s_axis.tready = !areset && !full;
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign dout_valid    = !empty;

  axis_s_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .areset  (areset),
    .wr_en   (accept),
    .wr_data ({s_axis.tlast, s_axis.tdata}),
    .rd_en   (rd_en),
    .head    ({dout_last, dout}),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      pkt_count <= '0;
      len_err   <= 1'b0;
    end else if (accept) begin
      if (s_axis.tlast) begin
        // A closing beat can itself be the one that overruns the limit
        if (state == RECV && beat_cnt == BEAT_MAX) len_err <= 1'b1;
        pkt_count <= pkt_count + 1'b1;
        beat_cnt  <= '0;
        state     <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            beat_cnt <= BW'(1);
            state    <= RECV;
          end
          RECV: begin
            if (beat_cnt == BEAT_MAX) begin
              len_err  <= 1'b1;
              beat_cnt <= BEAT_SAT;
              state    <= OVER;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
          OVER:    beat_cnt <= BEAT_SAT;
          default: state    <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_axis_s_rx_buffer.sv
// Self-checking bench for axis_s_rx_buffer: vector table plus scoreboard-backed corner sequences.
module tb_axis_s_rx_buffer;
  import axis_s_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int MAXL  = 4;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_last;
  logic          dout_valid;
  logic [3:0]    fifo_count;
  logic [7:0]    pkt_count;
  logic          len_err;

  axis_s_if #(.DATA_W(DW)) s_axis ();

  axis_s_rx_buffer #(
    .DATA_W      (DW),
    .DEPTH       (DEPTH),
    .MAX_PKT_LEN (MAXL)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .s_axis     (s_axis),
    .rd_en      (rd_en),
    .dout       (dout),
    .dout_last  (dout_last),
    .dout_valid (dout_valid),
    .fifo_count (fifo_count),
    .pkt_count  (pkt_count),
    .len_err    (len_err)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Reference model: queue of expected {tlast, tdata} plus occupancy and framing counters
  logic [DW:0] sb[$];
  int          mcount = 0;
  logic [7:0]  mpkt = '0;
  logic        merr = 1'b0;
  int          mlen = 0;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          l;
    logic          r;
    int            exp_cnt;
    int            exp_pkt;
    logic          exp_err;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check outputs against the model, advance model
  task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic r,
                      output logic acc);
    logic pop;
    @(negedge clk);
    s_axis.tvalid = v;
    s_axis.tdata  = d;
    s_axis.tlast  = l;
    rd_en         = r;
    #1;
    chk("tready",     s_axis.tready, mcount != DEPTH);
    chk("dout_valid", dout_valid,    mcount != 0);
    chk("fifo_count", fifo_count,    mcount);
    chk("pkt_count",  pkt_count,     mpkt);
    chk("len_err",    len_err,       merr);
    acc = v && (mcount != DEPTH);
    pop = r && (mcount != 0);
    if (pop) begin
      chk("dout_head", {dout_last, dout}, sb[0]);
      void'(sb.pop_front());
    end
    if (acc) begin
      sb.push_back({l, d});
      mlen++;
      if (mlen > MAXL) merr = 1'b1;
      if (l) begin
        mpkt++;
        mlen = 0;
      end
    end
    mcount = mcount + int'(acc) - int'(pop);
    @(posedge clk);
  endtask

  initial begin
    logic acc;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tlast  = 1'b0;

    tbl[0]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 1, 0, 1'b0};
    tbl[1]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1, 0, 1'b0};
    tbl[2]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1, 0, 1'b0};
    tbl[3]  = '{1'b1, 8'hA3, 1'b1, 1'b1, 1, 1, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1, 1'b0};
    tbl[5]  = '{1'b1, 8'hB0, 1'b0, 1'b0, 1, 1, 1'b0};
    tbl[6]  = '{1'b1, 8'hB1, 1'b0, 1'b0, 2, 1, 1'b0};
    tbl[7]  = '{1'b1, 8'hB2, 1'b1, 1'b0, 3, 2, 1'b0};
    tbl[8]  = '{1'b1, 8'hB3, 1'b0, 1'b1, 3, 2, 1'b0};
    tbl[9]  = '{1'b1, 8'hB4, 1'b1, 1'b1, 3, 3, 1'b0};
    tbl[10] = '{1'b1, 8'hB5, 1'b0, 1'b1, 3, 3, 1'b0};
    tbl[11] = '{1'b1, 8'hB6, 1'b0, 1'b1, 3, 3, 1'b0};
    tbl[12] = '{1'b1, 8'hB7, 1'b1, 1'b1, 3, 4, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 2, 4, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 4, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 4, 1'b0};

    // Reset state
    #12;
    chk("rst_tready",     s_axis.tready, 0);
    chk("rst_dout_valid", dout_valid,    0);
    chk("rst_fifo_count", fifo_count,    0);
    chk("rst_pkt_count",  pkt_count,     0);
    chk("rst_len_err",    len_err,       0);
    @(negedge clk);
    areset = 1'b0;

    // 4-beat packet with rd_en held, then fill-to-3 and balanced push/pop
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r, acc);
      #1;
      chk("tbl_fifo_count", fifo_count, tbl[i].exp_cnt);
      chk("tbl_pkt_count",  pkt_count,  tbl[i].exp_pkt);
      chk("tbl_len_err",    len_err,    tbl[i].exp_err);
    end

    // Backpressure: 10 beats into an 8-deep FIFO with no reads
    for (int i = 1; i <= 8; i++) step(1'b1, 8'h10 + 8'(i), (i % 2) == 0, 1'b0, acc);
    #1;
    chk("bp_full_count",  fifo_count,    8);
    chk("bp_full_tready", s_axis.tready, 0);
    step(1'b1, 8'h19, 1'b0, 1'b0, acc);
    step(1'b1, 8'h19, 1'b0, 1'b0, acc);
    step(1'b1, 8'h19, 1'b0, 1'b1, acc);
    #1;
    chk("bp_after_pop_tready", s_axis.tready, 1);
    chk("bp_after_pop_count",  fifo_count,    7);
    step(1'b1, 8'h19, 1'b0, 1'b0, acc);
    #1;
    chk("bp_beat9_count", fifo_count, 8);
    step(1'b1, 8'h1A, 1'b1, 1'b1, acc);
    step(1'b1, 8'h1A, 1'b1, 1'b0, acc);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 1'b1, acc);
    #1;
    chk("bp_drained", fifo_count, 0);
    chk("bp_pkts",    pkt_count,  9);

    // Overlong packet: 6 beats against a limit of 4
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'h40 + 8'(i), i == 5, 1'b1, acc);
      #1;
      if (i == 3) chk("len_err_at_4", len_err, 0);
      if (i == 4) chk("len_err_at_5", len_err, 1);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, acc);
    #1;
    chk("ovr_pkt_count", pkt_count, 10);
    chk("ovr_len_err",   len_err,   1);

    // Async reset mid-packet with 5 entries held
    for (int i = 0; i < 5; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, acc);
    @(negedge clk);
    s_axis.tvalid = 1'b0;
    rd_en         = 1'b0;
    #2 areset = 1'b1;
    #1;
    chk("arst_tready",     s_axis.tready, 0);
    chk("arst_dout_valid", dout_valid,    0);
    chk("arst_fifo_count", fifo_count,    0);
    chk("arst_pkt_count",  pkt_count,     0);
    chk("arst_len_err",    len_err,       0);
    sb.delete();
    mcount = 0;
    mpkt   = '0;
    merr   = 1'b0;
    mlen   = 0;
    @(negedge clk);
    areset = 1'b0;
    step(1'b1, 8'h55, 1'b1, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, 1'b1, acc);
    #1;
    chk("post_rst_pkt", pkt_count, 1);
    chk("post_rst_err", len_err,   0);

    // pkt_count wrap: 255 more single-beat packets bring 1 back to 0
    for (int i = 0; i < 255; i++) step(1'b1, 8'(i), 1'b1, 1'b1, acc);
    step(1'b0, 8'h00, 1'b0, 1'b1, acc);
    #1;
    chk("wrap_pkt_count", pkt_count, 0);

    // Reads on an empty FIFO are ignored
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1, acc);
    #1;
    chk("underflow_count", fifo_count, 0);
    chk("underflow_valid", dout_valid, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
